// File: rtl/ahb_decoder_resp_mux.sv
// ---------------------------------------------------------------------------
// ahb_decoder_resp_mux
//   AHB-Lite address decoder and data-phase response mux for one master port.
//   The address-phase HADDR is decoded to a one-hot slave select. That select
//   is registered into the data phase and steers HRDATA/HREADY/HRESP from the
//   selected slave back to the master. Unmapped active transfers go to a
//   built-in default slave. It answers with a two-cycle ERROR response and
//   counts each such transfer in a saturating counter.
//
// Ports
//   i_clk, i_rst    clock, asynchronous active-high reset
//   i_haddr         address-phase address
//   i_htrans        address-phase HTRANS (bit 1 = NONSEQ/SEQ)
//   o_hsel          one-hot address-phase slave select (combinational)
//   i_hrdata_s      packed slave read data, slave k at [k*DATA_WIDTH +: DATA_WIDTH]
//   i_hreadyout_s   per-slave HREADYOUT
//   i_hresp_s       per-slave HRESP (1 = ERROR)
//   o_hrdata        muxed read data
//   o_hready        muxed HREADY (also broadcast to the slaves)
//   o_hresp         muxed HRESP
//   o_err_cnt       saturating count of unmapped active transfers
// ---------------------------------------------------------------------------
module ahb_decoder_resp_mux #(
  parameter int NUM_SLAVES    = 2,
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int ERR_CNT_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR [NUM_SLAVES] = '{32'h0000_0000, 32'h1000_0000},
  parameter logic [ADDR_WIDTH-1:0] END_ADDR   [NUM_SLAVES] = '{32'h0FFF_FFFF, 32'h1FFF_FFFF}
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic [ADDR_WIDTH-1:0]            i_haddr,
  input  logic [1:0]                       i_htrans,
  output logic [NUM_SLAVES-1:0]            o_hsel,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] i_hrdata_s,
  input  logic [NUM_SLAVES-1:0]            i_hreadyout_s,
  input  logic [NUM_SLAVES-1:0]            i_hresp_s,
  output logic [DATA_WIDTH-1:0]            o_hrdata,
  output logic                             o_hready,
  output logic                             o_hresp,
  output logic [ERR_CNT_WIDTH-1:0]         o_err_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [NUM_SLAVES-1:0]    dsel_q, dsel_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

  logic [NUM_SLAVES-1:0]    hsel;
  logic                     any_hit;
  logic                     dflt_hit;
  logic [DATA_WIDTH-1:0]    hrdata;
  logic                     hready;
  logic                     hresp;

  // HTRANS[0] only separates BUSY from IDLE and SEQ from NONSEQ, which the
  // decoder does not need to know.
  logic unused_htrans0;
  assign unused_htrans0 = i_htrans[0];

  // Address decode. The first matching region wins, so overlapping maps
  // still give a one-hot select. A region whose start lies above its end
  // can never satisfy both compares.
  always_comb begin
    hsel    = '0;
    any_hit = 1'b0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (!any_hit && (i_haddr >= START_ADDR[k]) && (i_haddr <= END_ADDR[k])) begin
        hsel[k] = 1'b1;
        any_hit = 1'b1;
      end
    end
    dflt_hit = !any_hit && i_htrans[1];
  end

  assign o_hsel = hsel;

  // Response mux. The default-slave states override the slave path. In
  // those states dsel_q is zero anyway, because the transfer was unmapped.
  always_comb begin
    hrdata = '0;
    hready = 1'b1;
    hresp  = 1'b0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (dsel_q[k]) begin
        hrdata = i_hrdata_s[k*DATA_WIDTH +: DATA_WIDTH];
        hready = i_hreadyout_s[k];
        hresp  = i_hresp_s[k];
      end
    end
    case (state_q)
      ST_ERR1: begin
        hrdata = '0;
        hready = 1'b0;
        hresp  = 1'b1;
      end
      ST_ERR2: begin
        hrdata = '0;
        hready = 1'b1;
        hresp  = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_hrdata  = hrdata;
  assign o_hready  = hready;
  assign o_hresp   = hresp;
  assign o_err_cnt = err_cnt_q;

  // Next-state logic: data-phase select, default-slave FSM, error counter.
  always_comb begin
    dsel_d    = dsel_q;
    state_d   = state_q;
    err_cnt_d = err_cnt_q;

    // The data-phase select advances only when the current transfer completes.
    if (hready) begin
      dsel_d = hsel & {NUM_SLAVES{i_htrans[1]}};
    end

    case (state_q)
      ST_IDLE: if (hready && dflt_hit) state_d = ST_ERR1;
      ST_ERR1: state_d = ST_ERR2;
      ST_ERR2: state_d = dflt_hit ? ST_ERR1 : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Count every entry into ERR1. The counter sticks at all-ones.
    if ((state_d == ST_ERR1) && (state_q != ST_ERR1) && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
    end
  end

  // Data-phase register stage
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      dsel_q    <= '0;
      state_q   <= ST_IDLE;
      err_cnt_q <= '0;
    end else begin
      dsel_q    <= dsel_d;
      state_q   <= state_d;
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_ahb_decoder_resp_mux.sv
module tb_ahb_decoder_resp_mux;

  localparam logic [31:0] S0_DATA = 32'hA0A0_0000;
  localparam logic [31:0] S1_DATA = 32'hB1B1_0001;

  logic        clk;
  logic        rst;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic [1:0]  hsel;
  logic [63:0] hrdata_s;
  logic [1:0]  hreadyout_s;
  logic [1:0]  hresp_s;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;
  logic [7:0]  err_cnt;

  // Second instance with slave1 overlapping the top half of slave0.
  logic [31:0] ov_haddr;
  logic [1:0]  ov_hsel;
  logic [31:0] ov_hrdata;
  logic        ov_hready;
  logic        ov_hresp;
  logic [7:0]  ov_err_cnt;

  int tests = 0;
  int fails = 0;

  ahb_decoder_resp_mux dut (
    .i_clk(clk), .i_rst(rst), .i_haddr(haddr), .i_htrans(htrans), .o_hsel(hsel),
    .i_hrdata_s(hrdata_s), .i_hreadyout_s(hreadyout_s), .i_hresp_s(hresp_s),
    .o_hrdata(hrdata), .o_hready(hready), .o_hresp(hresp), .o_err_cnt(err_cnt)
  );

  ahb_decoder_resp_mux #(
    .START_ADDR('{32'h0000_0000, 32'h0800_0000}),
    .END_ADDR  ('{32'h0FFF_FFFF, 32'h1FFF_FFFF})
  ) dut_ov (
    .i_clk(clk), .i_rst(rst), .i_haddr(ov_haddr), .i_htrans(2'b00), .o_hsel(ov_hsel),
    .i_hrdata_s(hrdata_s), .i_hreadyout_s(2'b11), .i_hresp_s(2'b00),
    .o_hrdata(ov_hrdata), .o_hready(ov_hready), .o_hresp(ov_hresp), .o_err_cnt(ov_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // ------------------------------------------------------------------
  // Reference model: tracks what the current data phase belongs to
  // (nothing, a mapped slave, or the default slave and which of its two
  // response cycles is showing) plus the number of unmapped accesses.
  // ------------------------------------------------------------------
  localparam logic [31:0] M_START [2] = '{32'h0000_0000, 32'h1000_0000};
  localparam logic [31:0] M_END   [2] = '{32'h0FFF_FFFF, 32'h1FFF_FFFF};

  function automatic int region_of(input logic [31:0] a);
    for (int k = 0; k < 2; k++) begin
      if (a >= M_START[k] && a <= M_END[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [1:0] exp_sel(input logic [31:0] a);
    int r;
    logic [1:0] s;
    r = region_of(a);
    s = 2'b00;
    if (r == 0) s = 2'b01;
    if (r == 1) s = 2'b10;
    return s;
  endfunction

  int          m_tgt;    // -1 none, 0/1 slave, 2 default slave
  int          m_second; // default slave: 0 = first (wait) cycle, 1 = second
  int          m_cnt;
  logic        e_rdy;
  logic        e_resp;
  logic [31:0] e_data;

  always_comb begin
    e_rdy  = 1'b1;
    e_resp = 1'b0;
    e_data = 32'h0;
    if (m_tgt == 2) begin
      e_rdy  = (m_second != 0);
      e_resp = 1'b1;
    end else if (m_tgt == 0) begin
      e_rdy  = hreadyout_s[0];
      e_resp = hresp_s[0];
      e_data = hrdata_s[31:0];
    end else if (m_tgt == 1) begin
      e_rdy  = hreadyout_s[1];
      e_resp = hresp_s[1];
      e_data = hrdata_s[63:32];
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_tgt    <= -1;
      m_second <= 0;
      m_cnt    <= 0;
    end else if (e_rdy) begin
      if (!htrans[1]) begin
        m_tgt <= -1;
      end else if (region_of(haddr) < 0) begin
        m_tgt    <= 2;
        m_second <= 0;
        if (m_cnt < 255) m_cnt <= m_cnt + 1;
      end else begin
        m_tgt <= region_of(haddr);
      end
    end else if (m_tgt == 2) begin
      m_second <= 1;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("cmp_hsel",    {30'h0, hsel},   {30'h0, exp_sel(haddr)});
    chk("cmp_hready",  {31'h0, hready}, {31'h0, e_rdy});
    chk("cmp_hresp",   {31'h0, hresp},  {31'h0, e_resp});
    chk("cmp_hrdata",  hrdata,          e_data);
    chk("cmp_err_cnt", {24'h0, err_cnt}, m_cnt[31:0]);
  end

  initial begin
    rst         = 1'b1;
    haddr       = 32'h0;
    htrans      = 2'b00;
    hrdata_s    = {S1_DATA, S0_DATA};
    hreadyout_s = 2'b11;
    hresp_s     = 2'b00;
    ov_haddr    = 32'h0;
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    chk("rst_hready",  {31'h0, hready}, 32'h1);
    chk("rst_hresp",   {31'h0, hresp},  32'h0);
    chk("rst_hrdata",  hrdata,          32'h0);
    chk("rst_err_cnt", {24'h0, err_cnt}, 32'h0);
    cyc();

    // Slave0 transfer with two wait states, then slave1 transfer.
    haddr = 32'h0000_0000; htrans = 2'b10;
    #1 chk("t2_hsel0", {30'h0, hsel}, 32'h1);
    cyc();
    haddr = 32'h1000_0004; htrans = 2'b10; hreadyout_s = 2'b10;
    #1 chk("t2_hsel1", {30'h0, hsel}, 32'h2);
    chk("t2_wait1", {31'h0, hready}, 32'h0);
    cyc();
    #1 chk("t2_wait2", {31'h0, hready}, 32'h0);
    chk("t2_s0data", hrdata, S0_DATA);
    cyc();
    hreadyout_s = 2'b11;
    #1 chk("t2_s0done", {31'h0, hready}, 32'h1);
    chk("t2_s0data_done", hrdata, S0_DATA);
    cyc();
    htrans = 2'b00;
    #1 chk("t2_s1data", hrdata, S1_DATA);
    cyc();

    // Unmapped NONSEQ: ERROR in two cycles, counter 0 -> 1.
    haddr = 32'h2000_0000; htrans = 2'b10;
    #1 chk("t3_hsel", {30'h0, hsel}, 32'h0);
    chk("t3_cnt0", {24'h0, err_cnt}, 32'h0);
    cyc();
    htrans = 2'b00;
    #1 chk("t3_err1", {30'h0, hready, hresp}, 32'h1);
    chk("t3_cnt1", {24'h0, err_cnt}, 32'h1);
    cyc();
    #1 chk("t3_err2", {30'h0, hready, hresp}, 32'h3);
    cyc();
    #1 chk("t3_idle", {30'h0, hready, hresp}, 32'h2);

    // Reset in the middle of an ERROR response with junk on the inputs.
    haddr = 32'h2000_0000; htrans = 2'b10;
    cyc();
    haddr = 32'h1000_0000; hreadyout_s = 2'b00; hresp_s = 2'b11;
    hrdata_s = 64'hDEAD_BEEF_CAFE_F00D;
    #1 chk("t1_in_err1", {30'h0, hready, hresp}, 32'h1);
    rst = 1'b1;
    #1 chk("t1_hready", {31'h0, hready}, 32'h1);
    chk("t1_hresp",   {31'h0, hresp},  32'h0);
    chk("t1_hrdata",  hrdata,          32'h0);
    chk("t1_err_cnt", {24'h0, err_cnt}, 32'h0);
    chk("t1_hsel",    {30'h0, hsel},   32'h2);
    cyc();
    rst = 1'b0; htrans = 2'b00; hreadyout_s = 2'b11; hresp_s = 2'b00;
    hrdata_s = {S1_DATA, S0_DATA};
    cyc();

    // Back-to-back unmapped NONSEQ/SEQ: ERR1 ERR2 ERR1 ERR2.
    haddr = 32'h2000_0000; htrans = 2'b10;
    cyc();
    haddr = 32'h2000_0004; htrans = 2'b11;
    #1 chk("t4_err1a", {30'h0, hready, hresp}, 32'h1);
    cyc();
    #1 chk("t4_err2a", {30'h0, hready, hresp}, 32'h3);
    cyc();
    htrans = 2'b00;
    #1 chk("t4_err1b", {30'h0, hready, hresp}, 32'h1);
    chk("t4_cnt", {24'h0, err_cnt}, 32'h2);
    cyc();
    #1 chk("t4_err2b", {30'h0, hready, hresp}, 32'h3);
    cyc();

    // IDLE to unmapped space: zero-wait OKAY, no count.
    haddr = 32'h2000_0000; htrans = 2'b00;
    cyc();
    #1 chk("t5_idle_ok", {30'h0, hready, hresp}, 32'h2);
    chk("t5_idle_cnt", {24'h0, err_cnt}, 32'h2);

    // Drive the counter into saturation and past it.
    htrans = 2'b10;
    for (int i = 0; i < 600; i++) cyc();
    htrans = 2'b00;
    cyc();
    cyc();
    #1 chk("t5_sat", {24'h0, err_cnt}, 32'hFF);
    htrans = 2'b10;
    cyc();
    htrans = 2'b00;
    cyc();
    cyc();
    #1 chk("t5_sat_hold", {24'h0, err_cnt}, 32'hFF);

    // Region boundaries.
    haddr = 32'h0FFF_FFFF;
    #1 chk("t6_s0_end", {30'h0, hsel}, 32'h1);
    haddr = 32'h1000_0000;
    #1 chk("t6_s1_start", {30'h0, hsel}, 32'h2);
    haddr = 32'h1FFF_FFFF;
    #1 chk("t6_s1_end", {30'h0, hsel}, 32'h2);
    haddr = 32'h2000_0000; htrans = 2'b10;
    #1 chk("t6_unmapped", {30'h0, hsel}, 32'h0);
    cyc();
    htrans = 2'b00;
    #1 chk("t6_dflt", {30'h0, hready, hresp}, 32'h1);
    cyc();
    cyc();

    // Overlapping map: lowest index owns the shared range.
    ov_haddr = 32'h0900_0000;
    #1 chk("t6_ov_shared", {30'h0, ov_hsel}, 32'h1);
    ov_haddr = 32'h0800_0000;
    #1 chk("t6_ov_edge", {30'h0, ov_hsel}, 32'h1);
    ov_haddr = 32'h1800_0000;
    #1 chk("t6_ov_s1only", {30'h0, ov_hsel}, 32'h2);
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
